// File: rtl/dht11_sched.sv
// DHT11 read scheduler: periodic requests with power-up delay, timeout and failure tracking.
// The display value is registered from next-state data and mode, so it appears 1 cycle after a capture or key.
module dht11_sched #(
    parameter logic [26:0] PERIOD_MAX  = 27'd99_999_999,
    parameter logic [23:0] TIMEOUT_MAX = 24'd9_999_999,
    parameter logic [1:0]  FAIL_MAX    = 2'd2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        key_flag,
    input  logic        rd_done,
    input  logic        rd_err,
    input  logic [31:0] rd_data,
    output logic        rd_req,
    output logic        busy,
    output logic [19:0] data_out,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic        err_flag
);

    typedef enum logic [1:0] {PWRUP, REQ, READ, WAIT} state_t;

    state_t      state, state_nxt;
    logic [26:0] per_cnt;
    logic [23:0] to_cnt;
    logic [1:0]  fail_cnt;
    logic [1:0]  fail_inc;
    logic        mode, mode_nxt;
    logic        valid;
    logic [31:0] stored, stored_nxt;
    logic        capture, fail;

    function automatic logic [19:0] fmt(input logic [7:0] int_b, input logic [7:0] dec_b);
        logic [3:0] dec_c;
        dec_c = (dec_b[3:0] > 4'd9) ? 4'd9 : dec_b[3:0];
        return 20'(int_b) * 20'd10 + 20'(dec_c);
    endfunction

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= PWRUP;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        busy      = 1'b0;
        capture   = 1'b0;
        fail      = 1'b0;
        case (state)
            PWRUP: if (per_cnt == PERIOD_MAX) state_nxt = REQ;
            REQ: begin
                rd_req    = 1'b1;
                busy      = 1'b1;
                state_nxt = READ;
            end
            READ: begin
                busy = 1'b1;
                // A bad checksum wins over a simultaneous good-frame pulse.
                if (rd_err) begin
                    fail      = 1'b1;
                    state_nxt = WAIT;
                end else if (rd_done) begin
                    capture   = 1'b1;
                    state_nxt = WAIT;
                end else if (to_cnt == TIMEOUT_MAX) begin
                    fail      = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: if (per_cnt == PERIOD_MAX) state_nxt = REQ;
            default: state_nxt = PWRUP;
        endcase
    end

    always_comb begin
        fail_inc   = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;
        mode_nxt   = mode ^ key_flag;
        stored_nxt = capture ? rd_data : stored;
    end

    // Period counter free-runs through REQ and READ so request spacing is fixed.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            per_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            per_cnt <= (per_cnt == PERIOD_MAX) ? 27'd0 : per_cnt + 27'd1;
            if (state == REQ)       to_cnt <= '0;
            else if (state == READ) to_cnt <= to_cnt + 24'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fail_cnt <= '0;
            err_flag <= 1'b0;
            stored   <= '0;
            valid    <= 1'b0;
            mode     <= 1'b0;
        end else begin
            mode <= mode_nxt;
            if (capture) begin
                stored   <= rd_data;
                valid    <= 1'b1;
                fail_cnt <= '0;
                err_flag <= 1'b0;
            end else if (fail) begin
                fail_cnt <= fail_inc;
                if (fail_inc >= FAIL_MAX) err_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            data_out <= '0;
            sign     <= 1'b0;
            seg_en   <= 1'b0;
        end else begin
            data_out <= mode_nxt ? fmt(stored_nxt[31:24], stored_nxt[23:16])
                                 : fmt(stored_nxt[15:8], stored_nxt[7:0]);
            sign     <= ~mode_nxt & stored_nxt[7];
            seg_en   <= valid | capture;
        end
    end

    assign point = 6'b000_010;

endmodule

// File: tb/tb_dht11_sched.sv
// Randomized scoreboard bench for dht11_sched: driver plays the sensor on a pre-computed schedule.
module tb_dht11_sched;
    localparam int PER   = 100;
    localparam int TO    = 50;
    localparam int NR    = 26;
    localparam int RST_N = 20;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        key_flag = 1'b0;
    logic        rd_done = 1'b0;
    logic        rd_err = 1'b0;
    logic [31:0] rd_data = '0;
    logic        rd_req, busy, sign, seg_en, err_flag;
    logic [19:0] data_out;
    logic [5:0]  point;

    dht11_sched #(.PERIOD_MAX(27'd99), .TIMEOUT_MAX(24'd49), .FAIL_MAX(2'd2)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_flag(key_flag), .rd_done(rd_done),
        .rd_err(rd_err), .rd_data(rd_data), .rd_req(rd_req), .busy(busy),
        .data_out(data_out), .point(point), .sign(sign), .seg_en(seg_en), .err_flag(err_flag)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int data;
        bit sgn;
        bit seg;
        bit err;
        bit bsy;
    } exp_t;

    exp_t eq[$];
    int   rq[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: last good reading, mode and failure history.
    int m_hi, m_hd, m_ti, m_td, m_fail;
    bit m_mode, m_valid, m_err;

    function automatic int clampdec(int d);
        return ((d % 16) > 9) ? 9 : (d % 16);
    endfunction

    function automatic int disp();
        if (m_mode) return m_hi * 10 + clampdec(m_hd);
        return m_ti * 10 + clampdec(m_td);
    endfunction

    task automatic model_reset();
        m_hi = 0; m_hd = 0; m_ti = 0; m_td = 0; m_fail = 0;
        m_mode = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic push(input int c, input bit bsy);
        exp_t e;
        e.cyc  = c;
        e.data = disp();
        e.sgn  = !m_mode && (m_td >= 128);
        e.seg  = m_valid;
        e.err  = m_err;
        e.bsy  = bsy;
        eq.push_back(e);
    endtask

    task automatic chk(input string nm, input int c, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, c, got, want);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    always @(negedge sys_clk) begin : monitor
        int   r;
        exp_t e;
        if (rd_req) begin
            if (rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_req: unexpected pulse at cycle %0d, none due", cyc);
            end else begin
                r = rq.pop_front();
                chk("rd_req_cycle", cyc, cyc, r);
            end
        end
        while (eq.size() > 0 && eq[0].cyc <= cyc) begin
            e = eq.pop_front();
            chk("data_out", e.cyc, int'(data_out), e.data);
            chk("sign", e.cyc, int'(sign), int'(e.sgn));
            chk("seg_en", e.cyc, int'(seg_en), int'(e.seg));
            chk("err_flag", e.cyc, int'(err_flag), int'(e.err));
            chk("busy", e.cyc, int'(busy), int'(e.bsy));
            chk("point", e.cyc, int'(point), 2);
        end
    end

    initial begin
        int base, req, rc, j, n, scen;
        bit kco, klate, stray;
        logic [31:0] dat;

        model_reset();
        @(posedge sys_clk);
        #1;
        push(cyc, 0);
        wait_until(3);
        sys_rst = 1'b0;
        base = cyc;
        push(base, 0);

        j = 0;
        for (n = 0; n < NR; n++) begin
            req = base + PER * (j + 1);
            rq.push_back(req);
            wait_until(req);
            push(req, 1);

            if (n == RST_N) begin
                // Reset mid-read, then a late frame pulse that must be ignored.
                wait_until(req + 10);
                sys_rst = 1'b1;
                model_reset();
                push(req + 10, 0);
                wait_until(req + 12);
                sys_rst = 1'b0;
                base = cyc;
                rd_done = 1'b1;
                rd_data = $urandom;
                wait_until(base + 1);
                rd_done = 1'b0;
                push(base + 1, 0);
                j = 0;
                continue;
            end

            case (n)
                0, 1, 4: scen = 0;
                2, 3:    scen = 3;
                5:       scen = 2;
                RST_N + 1: scen = 0;
                default: scen = $urandom_range(0, 3);
            endcase
            dat   = (n == 0) ? 32'h3C00_1905 : (n == 1) ? 32'h2800_0A8C : $urandom;
            kco   = (n == RST_N + 1) ? 1'b1 : (n < 6) ? 1'b0 : ($urandom_range(0, 2) == 0);
            klate = (n < 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
            stray = (n == 5) ? 1'b1 : ($urandom_range(0, 2) == 0);
            rc    = (scen == 3) ? req + TO : req + $urandom_range(1, TO);

            wait_until(rc);
            push(rc, 1);
            rd_data  = dat;
            rd_done  = (scen == 0 || scen == 2);
            rd_err   = (scen == 1 || scen == 2);
            key_flag = kco;
            if (kco) m_mode = !m_mode;
            if (scen == 0) begin
                m_hi = int'(dat[31:24]); m_hd = int'(dat[23:16]);
                m_ti = int'(dat[15:8]);  m_td = int'(dat[7:0]);
                m_valid = 1; m_fail = 0; m_err = 0;
            end else begin
                m_fail = (m_fail >= 3) ? 3 : m_fail + 1;
                m_err  = m_err || (m_fail >= 2);
            end
            push(rc + 1, 0);
            wait_until(rc + 1);
            rd_done = 1'b0;
            rd_err = 1'b0;
            key_flag = 1'b0;

            if (klate) begin
                wait_until(rc + 3);
                key_flag = 1'b1;
                m_mode = !m_mode;
                push(rc + 4, 0);
                wait_until(rc + 4);
                key_flag = 1'b0;
            end
            if (stray) begin
                wait_until(rc + 6);
                if ($urandom_range(0, 1) == 1) rd_done = 1'b1;
                else rd_err = 1'b1;
                rd_data = $urandom;
                push(rc + 7, 0);
                wait_until(rc + 7);
                rd_done = 1'b0;
                rd_err = 1'b0;
            end
            j++;
        end

        wait_until(cyc + 20);
        chk("pending_req", cyc, rq.size(), 0);
        chk("pending_exp", cyc, eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
